// File: rtl/sipo_frame_ctrl.sv
//============================================================================
// Module      : sipo_frame_ctrl
// Description : Frame controller for a serial-in/parallel-out datapath.
//               Waits for a start strobe, shifts in WIDTH bit_en-qualified
//               serial bits (MSB first), presents the word on a registered
//               output with a valid/ready handshake and flags overruns.
//               Optional even-parity check enabled by SIPO_FRAME_PARITY_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module sipo_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_en,
    input  logic             data_in,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SHIFT = 2'd1;
`ifdef SIPO_FRAME_PARITY_EN
    localparam logic [1:0] C_PAR   = 2'd2;
`endif
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_commit_word;
    logic             w_commit;
`ifdef SIPO_FRAME_PARITY_EN
    logic             w_par_fail;
    logic             r_parity_err;
`endif

    // Shift register contents including the bit currently on data_in.
    assign w_word = {r_shreg[WIDTH-2:0], data_in};

    // Next-state decode and word-completion detection.
    always_comb begin
        w_state_next  = r_state;
        w_commit      = 1'b0;
        w_commit_word = w_word;
`ifdef SIPO_FRAME_PARITY_EN
        w_par_fail    = 1'b0;
`endif
        case (r_state)
            C_IDLE: begin
                if (start) w_state_next = C_SHIFT;
            end
            C_SHIFT: begin
                if (bit_en && (r_cnt == C_LAST)) begin
`ifdef SIPO_FRAME_PARITY_EN
                    w_state_next = C_PAR;
`else
                    w_state_next = C_IDLE;
                    w_commit     = 1'b1;
`endif
                end
            end
`ifdef SIPO_FRAME_PARITY_EN
            C_PAR: begin
                // The full word already sits in r_shreg; data_in is the parity bit.
                if (bit_en) begin
                    w_state_next  = C_IDLE;
                    w_commit_word = r_shreg;
                    if (^{r_shreg, data_in}) w_par_fail = 1'b1;
                    else                     w_commit   = 1'b1;
                end
            end
`endif
            default: w_state_next = C_IDLE;
        endcase
    end

    // State, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == C_IDLE) && start) begin
                r_cnt <= '0;
            end else if ((r_state == C_SHIFT) && bit_en) begin
                r_shreg <= w_word;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    // busy is registered from the next state so it matches the state register.
    always_ff @(posedge clk) begin
        if (rst) r_busy <= 1'b0;
        else     r_busy <= (w_state_next != C_IDLE);
    end

    // Output word, valid/ready handshake and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_commit) begin
            if (!r_valid || ready) begin
                r_data_out <= w_commit_word;
                r_valid    <= 1'b1;
            end else begin
                r_overrun  <= 1'b1;
            end
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    // One-cycle pulse when the received parity bit does not match.
    always_ff @(posedge clk) begin
        if (rst) r_parity_err <= 1'b0;
        else     r_parity_err <= w_par_fail;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out = r_data_out;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule

`default_nettype wire
